// File: rtl/cp_strip_stream.sv
`default_nettype none
// ==========================================================================
// cp_strip_stream -- drops the cyclic prefix of each OFDM symbol and streams
// the N_FFT body samples downstream.  Rev 1.0
// ==========================================================================
module cp_strip_stream #(
   parameter int DW    = 16,
   parameter int N_FFT = 64,
   parameter int N_CP  = 16
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic          STB_I,
   input  logic          SOF_I,
   input  logic [DW-1:0] DAT_I_r,
   input  logic [DW-1:0] DAT_I_i,
   output logic          ACK_O,
   output logic          STB_O,
   output logic [DW-1:0] DAT_O_r,
   output logic [DW-1:0] DAT_O_i,
   output logic          SOS_O,
   output logic          EOS_O,
   input  logic          ACK_I,
   output logic          ERR_O
);

   localparam int CW = $clog2(N_FFT);
   localparam logic [CW-1:0] CP_LAST   = CW'(N_CP - 1);
   localparam logic [CW-1:0] BODY_LAST = CW'(N_FFT - 1);
   // With a one-sample prefix the SOF sample itself is the whole prefix.
   localparam logic [CW-1:0] SOF_CNT   = (N_CP == 1) ? '0 : CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CP   = 2'd1,
      BODY = 2'd2
   } state_t;

   localparam state_t SOF_STATE = (N_CP == 1) ? BODY : CP;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            gap_err, gap_err_nx;
   logic            err_nx;
   logic            load;
   logic            xfer;

   assign ACK_O = (state != BODY) | ~STB_O | ACK_I;
   assign xfer  = STB_I & ACK_O;

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      gap_err_nx = gap_err;
      err_nx     = 1'b0;
      load       = 1'b0;
      if (xfer) begin
         if (SOF_I) begin
            // An SOF outside IDLE abandons the running symbol.
            state_nx   = SOF_STATE;
            cnt_nx     = SOF_CNT;
            gap_err_nx = 1'b0;
            err_nx     = (state != IDLE);
         end else begin
            case (state)
               IDLE: begin
                  if (!gap_err) begin
                     err_nx     = 1'b1;
                     gap_err_nx = 1'b1;
                  end
               end
               CP: begin
                  if (cnt == CP_LAST) begin
                     state_nx = BODY;
                     cnt_nx   = '0;
                  end else begin
                     cnt_nx = cnt + CW'(1);
                  end
               end
               BODY: begin
                  load = 1'b1;
                  if (cnt == BODY_LAST) begin
                     state_nx = IDLE;
                     cnt_nx   = '0;
                  end else begin
                     cnt_nx = cnt + CW'(1);
                  end
               end
               default: begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state   <= IDLE;
         cnt     <= '0;
         gap_err <= 1'b0;
         ERR_O   <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         gap_err <= gap_err_nx;
         ERR_O   <= err_nx;
      end
   end

   // One-entry output register; contents hold while stalled.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         STB_O   <= 1'b0;
         DAT_O_r <= '0;
         DAT_O_i <= '0;
         SOS_O   <= 1'b0;
         EOS_O   <= 1'b0;
      end else if (load) begin
         STB_O   <= 1'b1;
         DAT_O_r <= DAT_I_r;
         DAT_O_i <= DAT_I_i;
         SOS_O   <= (cnt == '0);
         EOS_O   <= (cnt == BODY_LAST);
      end else if (ACK_I) begin
         STB_O   <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cp_strip_stream.sv
`default_nettype none
// tb_cp_strip_stream -- directed + random scoreboard bench for cp_strip_stream.
module tb_cp_strip_stream;

   localparam int DW    = 16;
   localparam int N_FFT = 64;
   localparam int N_CP  = 16;
   localparam int SYM   = N_CP + N_FFT;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stb_i = 1'b0, sof_i = 1'b0, ack_i = 1'b1;
   logic [DW-1:0] dat_i_r = '0, dat_i_i = '0;
   logic          ack_o, stb_o, sos_o, eos_o, err_o;
   logic [DW-1:0] dat_o_r, dat_o_i;

   logic          stb1 = 1'b0, sof1 = 1'b0, ack1_i = 1'b1;
   logic [7:0]    d1r = '0, d1i = '0;
   logic          ack1_o, stb1_o, sos1_o, eos1_o, err1_o;
   logic [7:0]    do1r, do1i;

   int vectors = 0, miscompares = 0;
   int cyc = 0, out_cnt = 0, err_cnt = 0, sos_cyc = 0, last_out_cyc = 0;
   int ack_mode = 0, ack_phase = 0;
   logic [33:0] q[$];
   logic [33:0] exp_w;
   logic [34:0] held = '0;
   logic        held_v = 1'b0;

   cp_strip_stream #(.DW(DW), .N_FFT(N_FFT), .N_CP(N_CP)) u_dut (
      .CLK_I(clk), .RST_I(rst_n), .STB_I(stb_i), .SOF_I(sof_i),
      .DAT_I_r(dat_i_r), .DAT_I_i(dat_i_i), .ACK_O(ack_o), .STB_O(stb_o),
      .DAT_O_r(dat_o_r), .DAT_O_i(dat_o_i), .SOS_O(sos_o), .EOS_O(eos_o),
      .ACK_I(ack_i), .ERR_O(err_o)
   );

   cp_strip_stream #(.DW(8), .N_FFT(4), .N_CP(1)) u_dut_cp1 (
      .CLK_I(clk), .RST_I(rst_n), .STB_I(stb1), .SOF_I(sof1),
      .DAT_I_r(d1r), .DAT_I_i(d1i), .ACK_O(ack1_o), .STB_O(stb1_o),
      .DAT_O_r(do1r), .DAT_O_i(do1i), .SOS_O(sos1_o), .EOS_O(eos1_o),
      .ACK_I(ack1_i), .ERR_O(err1_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Downstream ready: 0 = always, 1 = 1,0,0,1 pattern, 2 = random, 3 = held low.
   initial forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
         0: ack_i = 1'b1;
         1: begin
            ack_i = (ack_phase == 0) || (ack_phase == 3);
            ack_phase = (ack_phase + 1) % 4;
         end
         2: ack_i = ($urandom_range(0, 1) == 1);
         default: ack_i = 1'b0;
      endcase
   end

   // Output monitor: scoreboard pop, stall-hold check, error pulse count.
   initial forever begin
      @(negedge clk);
      if (err_o) err_cnt++;
      if (held_v) check("hold_stable", {stb_o, dat_o_r, dat_o_i, sos_o, eos_o}, held);
      held_v = stb_o && !ack_i && rst_n;
      held   = {stb_o, dat_o_r, dat_o_i, sos_o, eos_o};
      if (stb_o && ack_i) begin
         if (sos_o) sos_cyc = cyc;
         last_out_cyc = cyc;
         out_cnt++;
         if (q.size() == 0) begin
            check("spurious_out", stb_o, 1'b0);
         end else begin
            exp_w = q.pop_front();
            check("out_sample", {dat_o_r, dat_o_i, sos_o, eos_o}, exp_w);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic xfer(input logic sof, input logic [DW-1:0] r, input logic [DW-1:0] im,
                       input bit body, input bit sos, input bit eos, input int gap_pct);
      int n;
      while ($urandom_range(0, 99) < gap_pct) begin
         stb_i = 1'b0;
         sof_i = 1'b0;
         @(posedge clk);
         #1;
      end
      stb_i = 1'b1; sof_i = sof; dat_i_r = r; dat_i_i = im;
      n = 0;
      @(negedge clk);
      while (!ack_o) begin
         n++;
         if (n > 1000) begin
            miscompares++;
            $display("FAIL accept_timeout observed=stalled expected=accepted");
            $fatal(1, "input never accepted");
         end
         @(negedge clk);
      end
      if (body) q.push_back({r, im, sos, eos});
      @(posedge clk);
      #1;
      stb_i = 1'b0;
      sof_i = 1'b0;
   endtask

   task automatic send_sym(input int base, input int k0, input int k1, input int gap_pct);
      logic [DW-1:0] v;
      for (int k = k0; k <= k1; k++) begin
         v = DW'(base + k);
         xfer(k == 0, v, -v, k >= N_CP, k == N_CP, k == SYM - 1, gap_pct);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check("drain_empty", q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int e0, o0, c0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stb", stb_o, 1'b0);
      check("rst_sos_eos_err", {sos_o, eos_o, err_o}, 3'b000);
      check("rst_dat", {dat_o_r, dat_o_i}, 32'd0);
      check("rst_ack", ack_o, 1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Nominal symbol
      e0 = err_cnt; o0 = out_cnt; c0 = cyc;
      send_sym(0, 0, SYM - 1, 0);
      check("nom_last_stb", stb_o, 1'b1);
      check("nom_last_eos", eos_o, 1'b1);
      check("nom_last_dat", dat_o_r, 16'd79);
      drain();
      check("nom_count", out_cnt - o0, N_FFT);
      check("nom_sos_latency", sos_cyc - c0, N_CP + 1);
      check("nom_err", err_cnt - e0, 0);

      // Back-to-back symbols
      e0 = err_cnt; o0 = out_cnt; c0 = cyc;
      for (int s = 0; s < 3; s++) send_sym(1000 + s * 100, 0, SYM - 1, 0);
      drain();
      check("b2b_count", out_cnt - o0, 3 * N_FFT);
      check("b2b_last_time", last_out_cyc - c0, 3 * SYM);
      check("b2b_err", err_cnt - e0, 0);

      // Backpressure; prefix accepted while downstream is not ready
      e0 = err_cnt; o0 = out_cnt;
      ack_mode = 3;
      c0 = cyc;
      send_sym(2000, 0, N_CP - 1, 0);
      check("bp_cp_cycles", cyc - c0, N_CP);
      ack_mode = 1;
      send_sym(2000, N_CP, SYM - 1, 0);
      send_sym(3000, 0, SYM - 1, 0);
      drain();
      ack_mode = 0;
      check("bp_count", out_cnt - o0, 2 * N_FFT);
      check("bp_err", err_cnt - e0, 0);

      // Early SOF at sample 50
      e0 = err_cnt; o0 = out_cnt;
      send_sym(4000, 0, 49, 0);
      send_sym(5000, 0, 0, 0);
      check("early_err_pulse", err_o, 1'b1);
      send_sym(5000, 1, SYM - 1, 0);
      drain();
      check("early_count", out_cnt - o0, 34 + N_FFT);
      check("early_err_cnt", err_cnt - e0, 1);

      // Missing SOF after a symbol
      e0 = err_cnt; o0 = out_cnt;
      for (int k = 0; k < 3; k++) xfer(1'b0, DW'(7000 + k), DW'(k), 1'b0, 1'b0, 1'b0, 0);
      send_sym(7100, 0, SYM - 1, 0);
      drain();
      check("gap_err_cnt", err_cnt - e0, 1);
      check("gap_count", out_cnt - o0, N_FFT);

      // Random gaps and random backpressure
      e0 = err_cnt; o0 = out_cnt;
      ack_mode = 2;
      for (int s = 0; s < 100; s++) send_sym(10000 + s * SYM, 0, SYM - 1, 50);
      drain();
      ack_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rand_count", out_cnt - o0, 100 * N_FFT);
      check("rand_err", err_cnt - e0, 0);

      // Asynchronous reset mid-body with a sample held in the output register
      send_sym(6000, 0, 29, 0);
      check("rst_pre_stb", stb_o, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_stb", stb_o, 1'b0);
      check("arst_flags", {sos_o, eos_o, err_o}, 3'b000);
      check("arst_dat", {dat_o_r, dat_o_i}, 32'd0);
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      e0 = err_cnt; o0 = out_cnt;
      for (int k = 0; k < 5; k++) xfer(1'b0, DW'(6100 + k), DW'(k), 1'b0, 1'b0, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_err", err_cnt - e0, 1);
      check("post_rst_no_out", out_cnt - o0, 0);
      send_sym(6200, 0, SYM - 1, 0);
      drain();
      check("post_rst_count", out_cnt - o0, N_FFT);

      // One-sample prefix build
      for (int k = 0; k < 5; k++) begin
         stb1 = 1'b1;
         sof1 = (k == 0);
         d1r  = 8'(10 + k);
         d1i  = ~d1r;
         @(posedge clk);
         #1;
         if (k == 0) check("ncp1_first_dropped", stb1_o, 1'b0);
         else check("ncp1_out", {stb1_o, do1r, do1i, sos1_o, eos1_o},
                    {1'b1, 8'(10 + k), ~8'(10 + k), k == 1, k == 4});
      end
      stb1 = 1'b0;
      sof1 = 1'b0;
      @(posedge clk);
      #1;
      check("ncp1_idle", {stb1_o, err1_o}, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
